// File: rtl/logic_event_counter_pkg.sv
// -----------------------------------------------------------------------------
// logic_event_counter_pkg
//
// Shared definitions for the logic_event_counter block:
//   - state_e       : FSM encoding (ST_IDLE = 1'b0, ST_RUN = 1'b1)
//   - SYNC_STAGES   : depth of the d_in clock-domain synchroniser
//   - SAT_W         : working width of the saturating helper
//   - sat_inc()     : saturating increment used for the event counter
//
// No ports (package).
// -----------------------------------------------------------------------------
package logic_event_counter_pkg;

  // Run-control FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Two flops are enough to resolve metastability on the asynchronous d_in.
  localparam int SYNC_STAGES = 2;

  // The helper works on a fixed 32-bit container; counters up to 32 bits wide
  // are zero-extended in and truncated back out by the caller.
  localparam int SAT_W = 32;

  // Returns val + inc, but never exceeds max_val.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] val,
    input logic             inc,
    input logic [SAT_W-1:0] max_val
  );
    logic [SAT_W-1:0] res;
    res = val;
    if (inc && (val < max_val)) begin
      res = val + 1'b1;
    end
    return res;
  endfunction

endpackage : logic_event_counter_pkg

// File: rtl/logic_event_counter_glitch_filter.sv
// -----------------------------------------------------------------------------
// glitch_filter
//
// Brings the asynchronous gate-network bit d_in into the clk domain and
// removes short glitches. The filtered level only changes after the
// synchronised input has disagreed with it for STABLE_CYCLES consecutive
// cycles; any agreeing cycle restarts the count.
//
// d_in edge to level change: SYNC_STAGES + STABLE_CYCLES clocks.
//
// Parameters:
//   STABLE_CYCLES : consecutive disagreeing samples needed to flip (>= 1)
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   d_in   in   raw gate-network output, may be asynchronous to clk
//   level  out  filtered, registered level of d_in
// -----------------------------------------------------------------------------
module glitch_filter
  import logic_event_counter_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level
);

  // stab_cnt only ever holds 0 .. STABLE_CYCLES-1: on the cycle it would hit
  // STABLE_CYCLES the level flips and the counter clears instead.
  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   synced;

  logic [STAB_W-1:0] stab_cnt_q;
  logic [STAB_W-1:0] stab_cnt_d;
  logic              level_q;
  logic              level_d;

  // Synchroniser chain: stage 0 samples d_in, each later stage samples the
  // one before it.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = d_in;
    end else begin : g_chain
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d    = level_q;
    stab_cnt_d = '0;
    if (synced != level_q) begin
      if (stab_cnt_q == STAB_LAST) begin
        level_d = ~level_q;
      end else begin
        stab_cnt_d = stab_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      stab_cnt_q <= '0;
      level_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      stab_cnt_q <= stab_cnt_d;
      level_q    <= level_d;
    end
  end

  assign level = level_q;

endmodule : glitch_filter

// File: rtl/logic_event_counter.sv
// -----------------------------------------------------------------------------
// logic_event_counter
//
// Consumes the single-bit output of the combinational gate stage: the bit is
// synchronised and glitch-filtered, rising edges of the filtered level are
// counted over fixed windows of WINDOW clocks, and each completed window
// count is offered on a single-entry valid/ready output register.
//
// Build option:
//   LOGIC_EVENT_COUNTER_FALL_EN  defined   -> count both edges (toggles)
//                                undefined -> count rising edges only
//
// Parameters:
//   STABLE_CYCLES : glitch-filter stability requirement (>= 1)
//   CNT_W         : event counter / cnt_data width (1 .. 32)
//   WINDOW        : window length in clk cycles (>= 2)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   run enable; dropping it abandons the current window
//   d_in       in   gate-network output, may be asynchronous to clk
//   level      out  filtered level of d_in
//   cnt_data   out  completed window count (saturating)
//   cnt_valid  out  cnt_data holds a count not yet taken
//   cnt_ready  in   consumer takes cnt_data this cycle
//   overrun    out  sticky: a window count was dropped because the output
//                   register was still full; cleared when a new run starts
// -----------------------------------------------------------------------------
module logic_event_counter
  import logic_event_counter_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int WINDOW        = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_in,
  output logic             level,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'({CNT_W{1'b1}});

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic filt_level;

  glitch_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_glitch_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (d_in),
    .level(filt_level)
  );

  assign level = filt_level;

  // ---------------------------------------------------------------------------
  // Edge detection against the previous filtered level
  // ---------------------------------------------------------------------------
  logic level_q;
  logic rise;
  logic evt;

  assign rise = filt_level & ~level_q;

`ifdef LOGIC_EVENT_COUNTER_FALL_EN
  logic fall;
  assign fall = ~filt_level & level_q;
  assign evt  = rise | fall;
`else
  assign evt  = rise;
`endif

  // ---------------------------------------------------------------------------
  // Window control, event counter and output register
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] ev_cnt_q;
  logic [CNT_W-1:0] cnt_data_q;
  logic             cnt_valid_q;
  logic             overrun_q;

  logic [CNT_W-1:0] ev_next;
  logic             win_end;
  logic             accept;
  logic             can_load;

  // ev_cnt plus this cycle's event. On the last window cycle this is also the
  // captured value, so an event on that cycle belongs to the ending window.
  assign ev_next  = CNT_W'(sat_inc(SAT_W'(ev_cnt_q), evt, CNT_MAX));
  assign win_end  = (win_cnt_q == WIN_LAST);
  assign accept   = cnt_valid_q & cnt_ready;
  // The register is free if empty, or if it is being emptied this very cycle
  // (back-to-back load without a bubble).
  assign can_load = ~cnt_valid_q | cnt_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      level_q     <= 1'b0;
      win_cnt_q   <= '0;
      ev_cnt_q    <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      level_q <= filt_level;

      // A load below overrides this clear when both happen together.
      if (accept) begin
        cnt_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          win_cnt_q <= '0;
          ev_cnt_q  <= '0;
          if (en) begin
            state_q   <= ST_RUN;
            overrun_q <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!en) begin
            // Partial window is abandoned; a pending count stays offered.
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            ev_cnt_q  <= '0;
          end else if (win_end) begin
            win_cnt_q <= '0;
            ev_cnt_q  <= '0;
            if (can_load) begin
              cnt_data_q  <= ev_next;
              cnt_valid_q <= 1'b1;
            end else begin
              // Unconsumed count wins; the new one is lost and flagged.
              overrun_q <= 1'b1;
            end
          end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
            ev_cnt_q  <= ev_next;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cnt_data  = cnt_data_q;
  assign cnt_valid = cnt_valid_q;
  assign overrun   = overrun_q;

endmodule : logic_event_counter

// File: tb/tb_logic_event_counter.sv
// -----------------------------------------------------------------------------
// tb_logic_event_counter
//
// Directed stimulus on a fixed cycle schedule (STABLE_CYCLES=4, CNT_W=3,
// WINDOW=100). Expected window counts are pushed into a queue as each window
// is stimulated; a separate monitor pops and compares whenever the DUT hands
// a count over (cnt_valid & cnt_ready), and also checks that cnt_data holds
// while a count is stalled.
//
// Timing used for the hand-computed expectations (E = edge after which en
// was raised, D = edge after which d_in was changed):
//   - level changes after edge D+6; the edge event is counted at edge D+7
//   - window k counts events at edges E+2+100k .. E+101+100k and its count is
//     visible after edge E+101+100k
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logic_event_counter;

  localparam int STABLE  = 4;
  localparam int CNT_W   = 3;
  localparam int WINDOW  = 100;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

`ifdef LOGIC_EVENT_COUNTER_FALL_EN
  localparam bit FALL_MODE = 1'b1;
`else
  localparam bit FALL_MODE = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             en        = 1'b0;
  logic             d_in      = 1'b0;
  logic             cnt_ready = 1'b0;
  logic             level;
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_valid;
  logic             overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  logic_event_counter #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (CNT_W),
    .WINDOW       (WINDOW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .d_in     (d_in),
    .level    (level),
    .cnt_data (cnt_data),
    .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected window count for a given number of rising/falling edges.
  function automatic int exp_cnt(input int rises, input int falls);
    int n;
    n = FALL_MODE ? (rises + falls) : rises;
    return (n > CNT_SAT) ? CNT_SAT : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance to 1 time unit after posedge number n.
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int start, input int len);
    go(start);
    d_in = 1'b1;
    go(start + len);
    d_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic             prev_hold;
    logic [CNT_W-1:0] prev_data;
    int               e;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (cnt_valid === 1'b1 && prev_hold) begin
        check("stalled_data_hold", 32'(cnt_data), 32'(prev_data));
      end
      if (cnt_valid === 1'b1 && cnt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_count: got %0d, expected no transfer (cycle %0d)", cnt_data, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("txn: cycle %0d window count %0d (expected %0d)", cyc, cnt_data, e);
          check("window_count", 32'(cnt_data), 32'(e));
        end
      end
      prev_hold = (cnt_valid === 1'b1) && (cnt_ready === 1'b0);
      prev_data = cnt_data;
    end
  end

  // Safety net: the schedule ends well before this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    int e1;
    int e2;

    // Reset held while d_in toggles: everything stays cleared.
    for (int i = 0; i < 12; i++) begin
      d_in = i[0];
      go(i + 1);
      check("rst_level", 32'(level), 32'd0);
      check("rst_cnt_valid", 32'(cnt_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_cnt_data", 32'(cnt_data), 32'd0);
    end
    d_in  = 1'b0;
    rst_n = 1'b1;

    go(20);
    en        = 1'b1;
    cnt_ready = 1'b1;
    e0        = 20;

    // Window 0: glitches of 1,2,3 cycles are filtered out; a 4-cycle pulse
    // set after E+32 raises level after E+38 and drops it after E+42.
    exp_q.push_back(exp_cnt(1, 1));
    for (int t = 2; t <= 45; t++) begin
      go(e0 + t);
      check("filter_level", 32'(level), 32'((t >= 38) && (t < 42)));
      d_in = ((t >= 2)  && (t < 3))  || ((t >= 12) && (t < 14)) ||
             ((t >= 22) && (t < 25)) || ((t >= 32) && (t < 36));
    end

    // Window 1: three clean 10-cycle pulses.
    exp_q.push_back(exp_cnt(3, 3));
    for (int j = 0; j < 3; j++) pulse(e0 + 110 + 20 * j, 10);

    // Window 2: nine 5-high/5-low pulses saturate the 3-bit counter.
    exp_q.push_back(exp_cnt(9, 9));
    for (int j = 0; j < 9; j++) pulse(e0 + 205 + 10 * j, 5);

    // Window 3: rise lands on the last window cycle (edge E+401).
    exp_q.push_back(exp_cnt(1, 0));
    pulse(e0 + 394, 10);
    cnt_ready = 1'b0;

    // Window 4: only the fall of the window-3 pulse (edge E+411); the next
    // rise lands on the first cycle of window 5 (edge E+502).
    exp_q.push_back(exp_cnt(0, 1));
    go(e0 + 495);
    d_in = 1'b1;
    go(e0 + 501);
    check("held_valid", 32'(cnt_valid), 32'd1);
    go(e0 + 505);
    d_in = 1'b0;

    // Window 5 ends while window 4 is still stalled: dropped, overrun set.
    go(e0 + 600);
    check("overrun_before_drop", 32'(overrun), 32'd0);
    check("valid_before_drop", 32'(cnt_valid), 32'd1);
    d_in = 1'b1;   // rise inside a partial window that will be abandoned
    go(e0 + 601);
    check("overrun_after_drop", 32'(overrun), 32'd1);
    check("valid_after_drop", 32'(cnt_valid), 32'd1);
    go(e0 + 604);
    d_in = 1'b0;
    go(e0 + 605);
    cnt_ready = 1'b1;  // window 4 count taken now
    go(e0 + 610);
    en = 1'b0;
    go(e0 + 612);
    check("overrun_sticky_idle", 32'(overrun), 32'd1);
    go(e0 + 615);
    check("overrun_before_rerun", 32'(overrun), 32'd1);
    en = 1'b1;
    e1 = e0 + 615;
    go(e1 + 1);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // New run: abandoned partial events must not carry over.
    exp_q.push_back(exp_cnt(1, 1));
    pulse(e1 + 10, 10);
    go(e1 + 50);
    cnt_ready = 1'b0;

    // Reset while the count is pending discards it.
    go(e1 + 105);
    check("valid_before_reset", 32'(cnt_valid), 32'd1);
    rst_n = 1'b0;
    void'(exp_q.pop_front());
    go(e1 + 106);
    check("reset_cnt_valid", 32'(cnt_valid), 32'd0);
    check("reset_cnt_data", 32'(cnt_data), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    go(e1 + 107);
    rst_n     = 1'b1;
    cnt_ready = 1'b1;
    e2        = e1 + 107;

    // After reset the FSM restarts from IDLE with a fresh window timer.
    exp_q.push_back(exp_cnt(1, 1));
    pulse(e2 + 20, 10);
    go(e2 + 100);
    check("restart_not_yet_valid", 32'(cnt_valid), 32'd0);
    go(e2 + 101);
    check("restart_window_valid", 32'(cnt_valid), 32'd1);
    go(e2 + 110);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_logic_event_counter
